// File: rtl/sdram_memtest.sv
// sdram_memtest: self-checking SDRAM traffic generator.
// Writes a selectable pattern over a word address range, reads the range
// back, compares each word against the regenerated pattern, and reports
// pass/fail plus details of the first mismatching word.
// One access is outstanding at a time and read data returns in order.
module sdram_memtest #(
  parameter int              AW         = 23,
  parameter int              DW         = 16,
  parameter logic [AW-1:0]   START_ADDR = '0,
  parameter logic [AW-1:0]   END_ADDR   = {AW{1'b1}},
  parameter logic [15:0]     SEED       = 16'hACE1,
  parameter int              TIMEOUT    = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    pattern_sel,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [15:0]   err_count,
  output logic [AW-1:0] err_addr,
  output logic [DW-1:0] err_exp,
  output logic [DW-1:0] err_got,
  output logic          bus_read,
  output logic          bus_write,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ready,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_REQ,
    S_RD_WAIT,
    S_DONE
  } state_t;

  // Watchdog fires on the cycle its count has reached TIMEOUT-1, i.e. after
  // TIMEOUT cycles spent waiting for read data.
  localparam logic [31:0] WdogLast = 32'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_stateNext;

  logic [AW-1:0] r_addr;
  logic [15:0]   r_lfsr;
  logic [1:0]    r_patSel;
  logic [31:0]   r_wdog;
  logic [15:0]   r_errCount;
  logic [AW-1:0] r_errAddr;
  logic [DW-1:0] r_errExp;
  logic [DW-1:0] r_errGot;
  logic          r_timeout;
  logic          r_pass;
  logic          r_fail;

  logic          w_lastAddr;
  logic          w_wdogExpired;
  logic [15:0]   w_addr16;
  logic [15:0]   w_pat16;
  logic [DW-1:0] w_expData;
  logic [15:0]   w_lfsrNext;
  logic          w_mismatch;
  logic [15:0]   w_errNext;

  // Address is compared against END before any increment, so a range that
  // ends at the top of the address space never needs to wrap.
  assign w_lastAddr    = (r_addr == END_ADDR);
  assign w_wdogExpired = (r_wdog == WdogLast);

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shift form; the write and
  // read phases both start from SEED so they walk the identical sequence.
  assign w_lfsrNext = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  // Pattern generator: 16-bit pattern for the current address, then fitted
  // to the bus width (zero-extended or truncated).
  always_comb begin
    w_addr16 = 16'(r_addr);
    w_pat16  = 16'h0000;
    case (r_patSel)
      2'd0:    w_pat16 = w_addr16;
      2'd1:    w_pat16 = ~w_addr16;
      2'd2:    w_pat16 = r_lfsr;
      default: w_pat16 = r_addr[0] ? 16'h5555 : 16'hAAAA;
    endcase
    w_expData = DW'(w_pat16);
  end

  // Read-back comparison and saturating error count.
  always_comb begin
    w_mismatch = (bus_rdata != w_expData);
    w_errNext  = r_errCount;
    if (w_mismatch && (r_errCount != 16'hFFFF)) begin
      w_errNext = r_errCount + 16'd1;
    end
  end

  // State register; reset returns to IDLE immediately, which also drops the
  // bus request strobes since they decode straight from the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode plus the state-derived bus and status outputs.
  always_comb begin
    w_stateNext = r_state;
    bus_write   = 1'b0;
    bus_read    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_stateNext = S_WRITE;
      end
      S_WRITE: begin
        bus_write = 1'b1;
        busy      = 1'b1;
        if (bus_ready && w_lastAddr) w_stateNext = S_RD_REQ;
      end
      S_RD_REQ: begin
        bus_read = 1'b1;
        busy     = 1'b1;
        if (bus_ready) w_stateNext = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        busy = 1'b1;
        if (bus_rvalid) begin
          w_stateNext = w_lastAddr ? S_DONE : S_RD_REQ;
        end else if (w_wdogExpired) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_stateNext = S_WRITE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Datapath: address/LFSR stepping, watchdog, error capture and the
  // pass/fail verdict which is registered as DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_lfsr     <= SEED;
      r_patSel   <= 2'd0;
      r_wdog     <= '0;
      r_errCount <= '0;
      r_errAddr  <= '0;
      r_errExp   <= '0;
      r_errGot   <= '0;
      r_timeout  <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_addr     <= START_ADDR;
            r_lfsr     <= SEED;
            r_patSel   <= pattern_sel;
            r_wdog     <= '0;
            r_errCount <= '0;
            r_errAddr  <= '0;
            r_errExp   <= '0;
            r_errGot   <= '0;
            r_timeout  <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
          end
        end
        S_WRITE: begin
          if (bus_ready) begin
            if (w_lastAddr) begin
              r_addr <= START_ADDR;
              r_lfsr <= SEED;
            end else begin
              r_addr <= r_addr + 1'b1;
              r_lfsr <= w_lfsrNext;
            end
          end
        end
        S_RD_REQ: begin
          if (bus_ready) r_wdog <= '0;
        end
        S_RD_WAIT: begin
          if (bus_rvalid) begin
            r_lfsr     <= w_lfsrNext;
            r_errCount <= w_errNext;
            if (w_mismatch && (r_errCount == 16'h0000)) begin
              r_errAddr <= r_addr;
              r_errExp  <= w_expData;
              r_errGot  <= bus_rdata;
            end
            if (w_lastAddr) begin
              r_pass <= (w_errNext == 16'h0000);
              r_fail <= (w_errNext != 16'h0000);
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end else if (w_wdogExpired) begin
            r_timeout <= 1'b1;
            r_fail    <= 1'b1;
            r_pass    <= 1'b0;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pass      = r_pass;
  assign fail      = r_fail;
  assign timeout   = r_timeout;
  assign err_count = r_errCount;
  assign err_addr  = r_errAddr;
  assign err_exp   = r_errExp;
  assign err_got   = r_errGot;
  assign bus_addr  = r_addr;
  assign bus_wdata = (r_state == S_WRITE) ? w_expData : '0;

endmodule

// File: tb/tb_sdram_memtest.sv
// tb_sdram_memtest: directed bench for sdram_memtest with a reactive bus
// model (ready two cycles after a request, read data three cycles after a
// read accept) and a write scoreboard fed from the bench's own pattern model.
module tb_sdram_memtest;

  localparam int AW      = 8;
  localparam int DW      = 16;
  localparam int TIMEOUT = 32;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic          start       = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic          busy;
  logic          done;
  logic          pass;
  logic          fail;
  logic          timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_exp;
  logic [DW-1:0] err_got;
  logic          bus_read;
  logic          bus_write;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ready   = 1'b0;
  logic          bus_rvalid  = 1'b0;
  logic [DW-1:0] bus_rdata   = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic holdReady = 1'b0;
  logic noRvalid  = 1'b0;
  logic flipEn    = 1'b0;
  int   flipAddr  = 5;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t expQ[$];

  logic [DW-1:0] mem [0:255];
  int            readyCnt      = 0;
  int            rdCnt         = 0;
  logic          rdPending     = 1'b0;
  logic [AW-1:0] rdAddr        = '0;
  logic [AW-1:0] expRdAddr     = '0;
  int            wrCount       = 0;
  int            rdCount       = 0;
  int            lastRvalidCyc = 0;
  int            readAcceptCyc = 0;

  sdram_memtest #(
    .AW(AW), .DW(DW), .START_ADDR(8'd0), .END_ADDR(8'd15),
    .SEED(16'hACE1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern_sel(pattern_sel),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .err_count(err_count), .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] patOf(input int sel, input int a, input logic [15:0] l);
    case (sel)
      0:       return 16'(a);
      1:       return ~16'(a);
      2:       return l;
      default: return (a % 2 == 1) ? 16'h5555 : 16'hAAAA;
    endcase
  endfunction

  // Bus model, driven on the falling edge so the DUT sees settled inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      readyCnt   = 0;
      rdPending  = 1'b0;
    end else begin
      if (bus_rvalid) bus_rvalid = 1'b0;
      if (rdPending) begin
        rdCnt--;
        if (rdCnt == 0) begin
          rdPending = 1'b0;
          if (!noRvalid) begin
            bus_rvalid    = 1'b1;
            bus_rdata     = mem[rdAddr] ^ ((flipEn && int'(rdAddr) == flipAddr) ? 16'h0001 : 16'h0000);
            rdCount++;
            lastRvalidCyc = cyc;
          end
        end
      end
      if (bus_ready) begin
        bus_ready = 1'b0;
        readyCnt  = 0;
      end else if ((bus_read || bus_write) && !holdReady) begin
        readyCnt++;
        if (readyCnt >= 2) begin
          bus_ready = 1'b1;
          if (bus_write) begin
            wr_t w;
            mem[bus_addr] = bus_wdata;
            wrCount++;
            expRdAddr = '0;
            checkOutput("wr_pending", 32'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
              w = expQ.pop_front();
              checkOutput("wr_addr", 32'(bus_addr), 32'(w.addr));
              checkOutput("wr_data", 32'(bus_wdata), 32'(w.data));
            end
          end else begin
            rdAddr        = bus_addr;
            rdPending     = 1'b1;
            rdCnt         = 3;
            readAcceptCyc = cyc + 1;
            checkOutput("rd_addr", 32'(bus_addr), 32'(expRdAddr));
            expRdAddr     = expRdAddr + 8'd1;
          end
        end
      end
    end
  end

  // Load the scoreboard with the 16 expected writes, then pulse start.
  task automatic applyStimulus(input int sel);
    logic [15:0] l;
    wr_t         w;
    l = 16'hACE1;
    expQ.delete();
    for (int a = 0; a < 16; a++) begin
      w.addr = 8'(a);
      w.data = patOf(sel, a, l);
      expQ.push_back(w);
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
    @(negedge clk);
    pattern_sel = 2'(sel);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int at);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    checkOutput("done_reached", 32'(done), 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int at;
    int wr0;
    int rd0;
    int n;
    logic [AW-1:0] snapA;
    logic [DW-1:0] snapD;
    logic unstable;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_passfail", 32'({pass, fail, timeout}), 0);
    checkOutput("rst_errcnt", 32'(err_count), 0);
    checkOutput("rst_bus", 32'({bus_read, bus_write}), 0);
    checkOutput("rst_addr", 32'(bus_addr), 0);
    checkOutput("rst_wdata", 32'(bus_wdata), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 0);

    // Pattern 0, clean memory
    wr0 = wrCount; rd0 = rdCount;
    applyStimulus(0);
    checkOutput("t1_busy", 32'(busy), 1);
    waitDone(2000, at);
    checkOutput("t1_pass", 32'(pass), 1);
    checkOutput("t1_fail", 32'(fail), 0);
    checkOutput("t1_errcnt", 32'(err_count), 0);
    checkOutput("t1_writes", 32'(wrCount - wr0), 16);
    checkOutput("t1_reads", 32'(rdCount - rd0), 16);
    checkOutput("t1_busy_lag", 32'(at - lastRvalidCyc), 1);
    checkOutput("t1_busy_low", 32'(busy), 0);
    checkOutput("t1_q_empty", 32'(expQ.size()), 0);

    // Single-bit fault at address 5
    flipEn = 1'b1;
    applyStimulus(0);
    checkOutput("t2_cleared", 32'({done, fail}), 0);
    waitDone(2000, at);
    flipEn = 1'b0;
    checkOutput("t2_fail", 32'(fail), 1);
    checkOutput("t2_pass", 32'(pass), 0);
    checkOutput("t2_errcnt", 32'(err_count), 1);
    checkOutput("t2_erraddr", 32'(err_addr), 5);
    checkOutput("t2_errexp", 32'(err_exp), 32'h0005);
    checkOutput("t2_errgot", 32'(err_got), 32'h0004);

    // LFSR pattern, then alternating checkerboard
    applyStimulus(2);
    waitDone(2000, at);
    checkOutput("t3_lfsr_pass", 32'(pass), 1);
    checkOutput("t3_lfsr_q", 32'(expQ.size()), 0);
    applyStimulus(3);
    waitDone(2000, at);
    checkOutput("t3_alt_pass", 32'(pass), 1);
    checkOutput("t3_alt_q", 32'(expQ.size()), 0);

    // Read data never returns
    noRvalid = 1'b1;
    applyStimulus(0);
    waitDone(2000, at);
    noRvalid = 1'b0;
    checkOutput("t4_timeout", 32'(timeout), 1);
    checkOutput("t4_fail", 32'(fail), 1);
    checkOutput("t4_pass", 32'(pass), 0);
    checkOutput("t4_latency", 32'(at - readAcceptCyc), 32);
    checkOutput("t4_errcnt", 32'(err_count), 0);

    // Stall mid-write with start pulses that must be ignored
    applyStimulus(0);
    checkOutput("t5_timeout_clr", 32'(timeout), 0);
    n = 0;
    while (!(bus_write && bus_addr == 8'd3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_reach_a3", 32'(bus_write && bus_addr == 8'd3), 1);
    holdReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    snapA    = bus_addr;
    snapD    = bus_wdata;
    unstable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = (i == 20 || i == 60);
      if (bus_addr !== snapA || bus_wdata !== snapD || bus_write !== 1'b1) unstable = 1'b1;
    end
    start = 1'b0;
    checkOutput("t5_stable", 32'(unstable), 0);
    checkOutput("t5_wdata", 32'(snapD), 32'(snapA));
    checkOutput("t5_busy", 32'(busy), 1);
    holdReady = 1'b0;
    waitDone(2000, at);
    checkOutput("t5_pass", 32'(pass), 1);
    checkOutput("t5_q_empty", 32'(expQ.size()), 0);

    // Asynchronous reset during the write phase
    applyStimulus(0);
    n = 0;
    while (!(bus_write && bus_addr == 8'd7) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_reach_a7", 32'(bus_write && bus_addr == 8'd7), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_write_drop", 32'(bus_write), 0);
    checkOutput("t6_busy_drop", 32'(busy), 0);
    expQ.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_idle", 32'({done, pass, fail}), 0);
    applyStimulus(0);
    waitDone(2000, at);
    checkOutput("t6_pass", 32'(pass), 1);
    checkOutput("t6_q_empty", 32'(expQ.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
